// File: rtl/window_gen_5x5_if.sv
// Pixel stream in, 5x5 window plus centre position and frame markers out.
interface window_gen_5x5_if #(
  parameter int pw = 9,
  parameter int cw = 10,
  parameter int rw = 10
);
  logic signed [pw-1:0] pixel_in;
  logic                 pixel_in_valid;
  logic                 sof;
  logic signed [pw-1:0] pixel1,  pixel2,  pixel3,  pixel4,  pixel5;
  logic signed [pw-1:0] pixel6,  pixel7,  pixel8,  pixel9,  pixel10;
  logic signed [pw-1:0] pixel11, pixel12, pixel13, pixel14, pixel15;
  logic signed [pw-1:0] pixel16, pixel17, pixel18, pixel19, pixel20;
  logic signed [pw-1:0] pixel21, pixel22, pixel23, pixel24, pixel25;
  logic                 window_valid;
  logic [rw-1:0]        center_row;
  logic [cw-1:0]        center_col;
  logic                 frame_done;

  modport master (
    output pixel_in, pixel_in_valid, sof,
    input  pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8, pixel9,
           pixel10, pixel11, pixel12, pixel13, pixel14, pixel15, pixel16, pixel17,
           pixel18, pixel19, pixel20, pixel21, pixel22, pixel23, pixel24, pixel25,
           window_valid, center_row, center_col, frame_done
  );

  modport slave (
    input  pixel_in, pixel_in_valid, sof,
    output pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8, pixel9,
           pixel10, pixel11, pixel12, pixel13, pixel14, pixel15, pixel16, pixel17,
           pixel18, pixel19, pixel20, pixel21, pixel22, pixel23, pixel24, pixel25,
           window_valid, center_row, center_col, frame_done
  );
endinterface

// File: rtl/window_gen_5x5.sv
// Streaming 5x5 sliding-window generator: four line buffers feed a 5x5 shift register.
// One window per accepted pixel, one cycle latency; no backpressure, idle cycles hold state.
module window_gen_5x5 #(
  parameter int pixel_int_width = 9,
  parameter int pixel_dec_width = 0,
  parameter int img_width       = 516,
  parameter int img_height      = 516,
  parameter int kernel_size     = 5
) (
  input logic             clk,
  input logic             rst,
  window_gen_5x5_if.slave bus
);
  localparam int pw = pixel_int_width + pixel_dec_width;
  localparam int cw = $clog2(img_width);
  localparam int rw = $clog2(img_height);

  localparam logic [cw-1:0] col_last  = cw'(img_width - 1);
  localparam logic [rw-1:0] row_last  = rw'(img_height - 1);
  localparam logic [cw-1:0] col_first = cw'(4);
  localparam logic [rw-1:0] row_first = rw'(4);

  typedef logic signed [pw-1:0] pix_t;

  if (kernel_size != 5) begin : g_bad_kernel
    $error("window_gen_5x5: kernel_size must be 5");
  end
  if (img_width < 5 || img_height < 5) begin : g_bad_size
    $error("window_gen_5x5: image must be at least 5x5");
  end

  logic [cw-1:0] col, cur_col, nxt_col;
  logic [rw-1:0] row, cur_row, nxt_row;
  logic          accept;
  pix_t          tap    [4];
  pix_t          wr_dat [4];
  pix_t          newest [5];
  pix_t          win    [5][5];
  logic          win_valid, done;
  logic [rw-1:0] crow;
  logic [cw-1:0] ccol;

  // sof overrides the counters so the accepted pixel lands at (0,0).
  always_comb begin
    accept  = bus.pixel_in_valid && !rst;
    cur_col = bus.sof ? '0 : col;
    cur_row = bus.sof ? '0 : row;
    nxt_col = cur_col + cw'(1);
    nxt_row = cur_row;
    if (cur_col == col_last) begin
      nxt_col = '0;
      nxt_row = (cur_row == row_last) ? '0 : cur_row + rw'(1);
    end
    wr_dat[0] = bus.pixel_in;
    for (int k = 1; k < 4; k++) wr_dat[k] = tap[k-1];
    newest[4] = bus.pixel_in;
    for (int i = 0; i < 4; i++) newest[i] = tap[3-i];
  end

  // Each buffer keeps a prefetch register for the next column and a shadow copy of
  // column 0, so a row wrap or an sof never waits on a memory read.
  for (genvar k = 0; k < 4; k++) begin : g_line
    pix_t mem [img_width];
    pix_t pf;
    pix_t shadow;

    always_ff @(posedge clk) begin
      if (accept) begin
        mem[cur_col] <= wr_dat[k];
        pf           <= mem[nxt_col];
        if (cur_col == '0) shadow <= wr_dat[k];
      end
    end

    assign tap[k] = (cur_col == '0) ? shadow : pf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      done      <= 1'b0;
      crow      <= '0;
      ccol      <= '0;
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) win[i][j] <= '0;
    end else begin
      win_valid <= 1'b0;
      done      <= 1'b0;
      if (bus.pixel_in_valid) begin
        col  <= nxt_col;
        row  <= nxt_row;
        for (int i = 0; i < 5; i++) begin
          for (int j = 0; j < 4; j++) win[i][j] <= win[i][j+1];
          win[i][4] <= newest[i];
        end
        win_valid <= (cur_row >= row_first) && (cur_col >= col_first);
        done      <= (cur_row == row_last) && (cur_col == col_last);
        crow      <= cur_row - rw'(2);
        ccol      <= cur_col - cw'(2);
      end
    end
  end

  assign bus.pixel1  = win[0][0]; assign bus.pixel2  = win[0][1]; assign bus.pixel3  = win[0][2];
  assign bus.pixel4  = win[0][3]; assign bus.pixel5  = win[0][4]; assign bus.pixel6  = win[1][0];
  assign bus.pixel7  = win[1][1]; assign bus.pixel8  = win[1][2]; assign bus.pixel9  = win[1][3];
  assign bus.pixel10 = win[1][4]; assign bus.pixel11 = win[2][0]; assign bus.pixel12 = win[2][1];
  assign bus.pixel13 = win[2][2]; assign bus.pixel14 = win[2][3]; assign bus.pixel15 = win[2][4];
  assign bus.pixel16 = win[3][0]; assign bus.pixel17 = win[3][1]; assign bus.pixel18 = win[3][2];
  assign bus.pixel19 = win[3][3]; assign bus.pixel20 = win[3][4]; assign bus.pixel21 = win[4][0];
  assign bus.pixel22 = win[4][1]; assign bus.pixel23 = win[4][2]; assign bus.pixel24 = win[4][3];
  assign bus.pixel25 = win[4][4];

  assign bus.window_valid = win_valid;
  assign bus.frame_done   = done;
  assign bus.center_row   = crow;
  assign bus.center_col   = ccol;
endmodule

// File: tb/tb_window_gen_5x5.sv
// Directed bench for window_gen_5x5 on an 8x6 image with pixel = 8*row+col.
module tb_window_gen_5x5;
  localparam int PW = 9;
  localparam int W  = 8;
  localparam int H  = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  window_gen_5x5_if #(.pw(PW), .cw(3), .rw(3)) bus ();

  window_gen_5x5 #(
    .pixel_int_width(9), .pixel_dec_width(0),
    .img_width(W), .img_height(H), .kernel_size(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic signed [PW-1:0] px [25];
  assign px[0]  = bus.pixel1;  assign px[1]  = bus.pixel2;  assign px[2]  = bus.pixel3;
  assign px[3]  = bus.pixel4;  assign px[4]  = bus.pixel5;  assign px[5]  = bus.pixel6;
  assign px[6]  = bus.pixel7;  assign px[7]  = bus.pixel8;  assign px[8]  = bus.pixel9;
  assign px[9]  = bus.pixel10; assign px[10] = bus.pixel11; assign px[11] = bus.pixel12;
  assign px[12] = bus.pixel13; assign px[13] = bus.pixel14; assign px[14] = bus.pixel15;
  assign px[15] = bus.pixel16; assign px[16] = bus.pixel17; assign px[17] = bus.pixel18;
  assign px[18] = bus.pixel19; assign px[19] = bus.pixel20; assign px[20] = bus.pixel21;
  assign px[21] = bus.pixel22; assign px[22] = bus.pixel23; assign px[23] = bus.pixel24;
  assign px[24] = bus.pixel25;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: 8r+c, mode 1: alternating -256/255, mode 2: 8r+c-200
  function automatic int val(input int mode, input int r, input int c);
    int n;
    n = 8 * r + c;
    if (mode == 1) return (n % 2 == 0) ? -256 : 255;
    if (mode == 2) return n - 200;
    return n;
  endfunction

  // Called at a negedge; returns at the next negedge with the result visible.
  task automatic push(input int p, input bit s);
    bus.pixel_in       = PW'(p);
    bus.pixel_in_valid = 1'b1;
    bus.sof            = s;
    @(negedge clk);
    bus.pixel_in_valid = 1'b0;
    bus.sof            = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    for (int k = 0; k < 25; k++) chk($sformatf("%s_px%0d", tag, k + 1), px[k], 0);
    chk({tag, "_valid"}, bus.window_valid, 0);
    chk({tag, "_done"}, bus.frame_done, 0);
    chk({tag, "_crow"}, bus.center_row, 0);
    chk({tag, "_ccol"}, bus.center_col, 0);
  endtask

  task automatic partial(input int n);
    for (int i = 0; i < n; i++) begin
      push(val(0, i / W, i % W), 1'b0);
      chk($sformatf("part_valid%0d", i), bus.window_valid, 0);
    end
  endtask

  task automatic run_frame(input string tag, input int mode, input int gap_max, input bit sof_first);
    int nwin;
    int g;
    logic signed [31:0] held25, heldc;
    bit exp_v;
    nwin = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        push(val(mode, r, c), sof_first && r == 0 && c == 0);
        if (bus.window_valid) nwin++;
        exp_v = (r >= 4) && (c >= 4);
        chk($sformatf("%s_valid@%0d,%0d", tag, r, c), bus.window_valid, exp_v);
        chk($sformatf("%s_done@%0d,%0d", tag, r, c), bus.frame_done, (r == H - 1 && c == W - 1));
        if (exp_v) begin
          for (int k = 0; k < 25; k++)
            chk($sformatf("%s_px%0d@%0d,%0d", tag, k + 1, r, c), px[k],
                val(mode, r - 4 + k / 5, c - 4 + k % 5));
          chk($sformatf("%s_crow@%0d,%0d", tag, r, c), bus.center_row, r - 2);
          chk($sformatf("%s_ccol@%0d,%0d", tag, r, c), bus.center_col, c - 2);
        end
        if (mode == 0 && r == 4 && c == 4) begin
          chk({tag, "_first_px1"}, px[0], 0);
          chk({tag, "_first_px5"}, px[4], 4);
          chk({tag, "_first_px13"}, px[12], 18);
          chk({tag, "_first_px21"}, px[20], 32);
          chk({tag, "_first_px25"}, px[24], 36);
          chk({tag, "_first_crow"}, bus.center_row, 2);
          chk({tag, "_first_ccol"}, bus.center_col, 2);
        end
        if (mode == 0 && r == 5 && c == 7) begin
          chk({tag, "_last_px25"}, px[24], 47);
          chk({tag, "_last_crow"}, bus.center_row, 3);
          chk({tag, "_last_ccol"}, bus.center_col, 5);
          chk({tag, "_last_done"}, bus.frame_done, 1);
        end
        if (gap_max > 0) begin
          g = $urandom_range(gap_max, 1);
          held25 = px[24];
          heldc  = bus.center_col;
          repeat (g) begin
            @(negedge clk);
            chk($sformatf("%s_gap_valid@%0d,%0d", tag, r, c), bus.window_valid, 0);
            chk($sformatf("%s_gap_done@%0d,%0d", tag, r, c), bus.frame_done, 0);
            chk($sformatf("%s_gap_px25@%0d,%0d", tag, r, c), px[24], held25);
            chk($sformatf("%s_gap_ccol@%0d,%0d", tag, r, c), bus.center_col, heldc);
          end
        end
      end
    end
    chk({tag, "_win_count"}, nwin, (W - 4) * (H - 4));
  endtask

  initial begin
    bus.pixel_in       = '0;
    bus.pixel_in_valid = 1'b0;
    bus.sof            = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    run_frame("first", 0, 0, 1'b1);
    run_frame("gaps", 0, 3, 1'b1);

    // Twenty pixels of a frame, then sof restarts at index 20 with distinct data.
    partial(20);
    run_frame("midsof", 2, 0, 1'b1);

    // Reset mid-frame with a simultaneous pixel, which must be dropped.
    partial(30);
    bus.pixel_in       = PW'(123);
    bus.pixel_in_valid = 1'b1;
    rst                = 1'b1;
    @(negedge clk);
    rst                = 1'b0;
    bus.pixel_in_valid = 1'b0;
    chk_zero("midrst");
    run_frame("afterrst", 0, 0, 1'b0);

    run_frame("sign", 1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/window_gen_5x5.md
# window_gen_5x5

Streaming 5x5 sliding-window generator that sits directly upstream of the 45-degree convolution block. It accepts one pixel per cycle in raster order and buffers the four previous image rows in line memories. For every pixel that completes a full 5x5 neighbourhood, it presents all 25 window pixels in parallel (`pixel1`..`pixel25`) with a one-cycle `window_valid` strobe. No border padding: only fully-populated windows are emitted.

## Interface
Parameters:
- `pixel_int_width`, 9: integer bits of a pixel (signed).
- `pixel_dec_width`, 0: fractional bits of a pixel.
- `img_width`, 516: pixels per row; must be ≥5.
- `img_height`, 516: rows per frame; must be ≥5.
- `kernel_size`, 5: fixed at 5; any other value is a configuration error.

Ports (PW = `pixel_int_width + pixel_dec_width`; CW = `$clog2(img_width)`; RW = `$clog2(img_height)`):
- `clk`  in  1  clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `pixel_in`  in  PW signed  incoming pixel.
- `pixel_in_valid`  in  1  `pixel_in` is accepted this cycle. There is no backpressure.
- `sof`  in  1  start of frame; qualified by `pixel_in_valid`.
- `pixel1`..`pixel25`  out  PW signed each  window, row-major.
  - `pixel1` is the top-left pixel (oldest row, oldest column).
  - `pixel5` is the top-right pixel.
  - `pixel21` is the bottom-left pixel.
  - `pixel25` is the newest accepted pixel.
- `window_valid`  out  1  the window outputs hold a new complete window this cycle.
- `center_row`  out  RW  row of the window centre pixel (`pixel13`).
- `center_col`  out  CW  column of the window centre pixel.
- `frame_done`  out  1  one-cycle pulse on the last window of a frame.

## Operation
- **Position counters** `col` (0..img_width-1) and `row` (0..img_height-1) give the position of the next accepted pixel.
  - They advance only when `pixel_in_valid`=1.
  - `col` wraps to 0 after img_width-1, and `row` then increments.
  - `row` wraps to 0 after img_height-1.
- **sof**: `pixel_in_valid`=1 with `sof`=1 forces the accepted pixel to position (0,0), regardless of the counter values. `sof` without `pixel_in_valid` is ignored.
- **Line buffers**: four single-port-equivalent buffers, each img_width × PW, addressed by `col`. On each accepted pixel:
  - read the four stored pixels at `col` (rows r-4..r-1);
  - write `pixel_in` into buffer 0 and shift each buffer's old value up one buffer.
  - The read and the shift occur in the same accepted cycle. BRAM read latency is hidden by a prefetch register, so throughput is 1 pixel/cycle sustained.
- **Window register**: a 5x5 array. On each accepted pixel, every row shifts left by one column. The new right column is (buffer3, buffer2, buffer1, buffer0, `pixel_in`), i.e. rows r-4..r.
- **Valid rule**: `window_valid`=1 in the cycle after accepting the pixel at (r,c) with r≥4 and c≥4. Otherwise `window_valid`=0.
  - Windows straddling a row wrap (c<4) are never flagged valid, even though the registers hold stale columns.
  - Windows that include rows of a previous frame (r<4) are never flagged valid.
- **Centre position**: `center_row`=r-2 and `center_col`=c-2, registered alongside the window.
- **frame_done**: asserted together with `window_valid` when r=img_height-1 and c=img_width-1.
- **Idle cycles** (`pixel_in_valid`=0): window, centre and counters hold; `window_valid` and `frame_done` are 0.
- **Reset**: all outputs go to 0; `col`, `row` and the window register go to 0. Line-buffer contents are not cleared; they are masked by the valid rule. Reset mid-frame discards the partial frame, and the next accepted pixel is (0,0).
- **Arithmetic**: none. Values are passed bit-exact; sign is preserved.

## Timing
- Latency: pixel accepted at edge t → window containing it is visible after edge t+1, with `window_valid` high for exactly that one cycle.
- Throughput: one window per accepted pixel once in steady state.
- Per frame: exactly (img_width-4)·(img_height-4) windows are emitted.
- Back-to-back frames need no gap. `sof` on the cycle after the last pixel of the previous frame is legal.
- Simultaneous `rst` and `pixel_in_valid`: reset wins and the pixel is dropped.

## Test plan
Bench configuration: img_width=8, img_height=6; stimulus pixel = 8·row+col.
- **First window**: one full frame streamed continuously with `sof` on pixel 0 → first `window_valid` one cycle after accepting pixel 36. That window has `pixel1`=0, `pixel5`=4, `pixel13`=18, `pixel21`=32, `pixel25`=36, `center_row`=2, `center_col`=2.
- **Window count and last window**: full frame → exactly 8 `window_valid` pulses. The last pulse has `pixel25`=47, `center`=(3,5), `frame_done`=1, and there are none at c<4.
- **Valid gaps**: same frame with random 1–3 idle cycles between pixels → identical window sequence. Outputs hold during gaps, and `window_valid`=0 during gaps.
- **Mid-frame sof**: `sof` asserted at pixel index 20 → that pixel is treated as (0,0). The next valid window follows 36 further accepted pixels and contains only post-`sof` data.
- **Reset mid-frame**: `rst` pulsed mid-frame → all outputs read 0 the next cycle. The following frame behaves as in the first-window scenario.
- **Sign extremes**: pixel_in alternating -256 and 255 → emitted window values match bit-exactly with sign preserved.
